// File: rtl/enc4to2.sv
// Capture-and-drain 4-to-2 request encoder: latches a request vector, then retires one grant per Ack.
// Define ROUND_ROBIN_EN for a rotating-priority pointer; otherwise bit 3 always wins.
module enc4to2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] w_i,
  input  logic       en_i,
  input  logic       ack_i,
  output logic [1:0] y_o,
  output logic       valid_o,
  output logic [3:0] pending_o
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q;
  logic [1:0] y_q;
  logic [3:0] pending_q;
  logic [3:0] remain;
  logic [1:0] ptr_cur;
  logic [1:0] ptr_after;

  // First set bit searching p, p-1, ... with wrap; p=3 gives plain highest-bit priority.
  function automatic logic [1:0] sel(input logic [3:0] cand, input logic [1:0] p);
    logic [1:0] idx;
    sel = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p - 2'(i);
      if (cand[idx]) sel = idx;
    end
  endfunction

  assign remain = pending_q & ~(4'b0001 << y_q);

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr_q;

  assign ptr_cur   = ptr_q;
  assign ptr_after = y_q - 2'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 2'd3;
    end else if (state_q == HOLD && ack_i) begin
      ptr_q <= ptr_after;
    end
  end
`else
  assign ptr_cur   = 2'd3;
  assign ptr_after = 2'd3;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      y_q       <= 2'b00;
      pending_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i && w_i != 4'b0000) begin
            pending_q <= w_i;
            y_q       <= sel(w_i, ptr_cur);
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (ack_i) begin
            pending_q <= remain;
            if (remain != 4'b0000) begin
              y_q <= sel(remain, ptr_after);
            end else begin
              // Y keeps the last granted index after the final retire.
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y_o       = y_q;
  assign valid_o   = (state_q == HOLD);
  assign pending_o = pending_q;

endmodule

// File: tb/tb_enc4to2.sv
// Directed bench for enc4to2: expected outputs are queued per step and compared one cycle later.
module tb_enc4to2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] w_i;
  logic       en_i;
  logic       ack_i;
  logic [1:0] y_o;
  logic       valid_o;
  logic [3:0] pending_o;

  typedef struct packed {
    logic [1:0] y;
    logic       valid;
    logic [3:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  enc4to2 dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .w_i       (w_i),
    .en_i      (en_i),
    .ack_i     (ack_i),
    .y_o       (y_o),
    .valid_o   (valid_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] req);
    total_cnt++;
    assert (act === req) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, req);
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input string tag, input logic [3:0] w, input logic en, input logic ack,
                      input logic [1:0] ey, input logic ev, input logic [3:0] ep);
    exp_t e;
    w_i   = w;
    en_i  = en;
    ack_i = ack;
    exp_q.push_back('{y: ey, valid: ev, pend: ep});
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".y"},       {2'b00, y_o},     {2'b00, e.y});
    chk({tag, ".valid"},   {3'b000, valid_o}, {3'b000, e.valid});
    chk({tag, ".pending"}, pending_o,        e.pend);
    $display("step %-10s w=%b en=%b ack=%b -> y=%0d valid=%b pending=%b",
             tag, w, en, ack, y_o, valid_o, pending_o);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    chk({tag, ".y"},       {2'b00, y_o},      4'h0);
    chk({tag, ".valid"},   {3'b000, valid_o}, 4'h0);
    chk({tag, ".pending"}, pending_o,         4'h0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    w_i   = 4'b0000;
    en_i  = 1'b0;
    ack_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst.y",       {2'b00, y_o},      4'h0);
    chk("rst.valid",   {3'b000, valid_o}, 4'h0);
    chk("rst.pending", pending_o,         4'h0);
    rst_i = 1'b0;

    // Fixed-priority drain with Ack held; En on the final Ack is ignored.
    step("cap1011", 4'b1011, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1011);
    step("ack1",    4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0011);
    step("ack2",    4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
    step("ack3en",  4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000);
    step("idle",    4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);

    // Empty capture and Ack in IDLE change nothing.
    step("capzero", 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000);
    step("ackidle", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);

    // Async reset mid-HOLD discards pending requests.
    step("cap1111", 4'b1111, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1111);
    step("ack1111", 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0111);
    async_reset_pulse("arst");
    step("postrst", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000);
    step("cap0001", 4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 4'b0001);
    step("ack0001", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);

    // Single request, 1-cycle latency, Y held after drain.
    step("cap0100", 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0100);
    step("ack0100", 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000);

    // HOLD ignores W/En while Ack is low.
    step("cap1100", 4'b1100, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1100);
    for (int i = 0; i < 5; i++) begin
      step("hold", 4'($urandom_range(0, 15)), 1'b1, 1'b0, 2'd3, 1'b1, 4'b1100);
    end
    step("ackh1",   4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100);
    step("ackh2",   4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000);

    async_reset_pulse("arst2");

`ifdef ROUND_ROBIN_EN
    step("rr1001a", 4'b1001, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1001);
    step("rrack1",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
    step("rrack2",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
    step("rr1001b", 4'b1001, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1001);
    step("rrack3",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
    step("rrack4",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
    step("rr1000",  4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1000);
    step("rrack5",  4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 4'b0000);
    step("rr0011",  4'b0011, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0011);
    step("rrack6",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
    step("rrack7",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
`else
    step("fx1001",  4'b1001, 1'b1, 1'b0, 2'd3, 1'b1, 4'b1001);
    step("fxack1",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
    step("fxack2",  4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000);
    step("fx0110",  4'b0110, 1'b1, 1'b0, 2'd2, 1'b1, 4'b0110);
    step("fxack3",  4'b0000, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010);
    step("fxack4",  4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
